// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for the word-addressed data memory.
// Sub-word stores go through read-modify-write; loads are extended.
module lsu_mem_ctrl #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData,
  output logic        MemRead,
  output logic        MemWrite
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  state_t state, state_n;

  logic        wr_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] widx;
  logic        oor;
  logic        req_err;
  logic        accept;
  logic        word_st;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign widx    = {2'b00, req_addr[31:2]};
  assign oor     = widx >= 32'(MEM_WORDS);
  assign req_err = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                 | oor;
  assign accept  = (state == IDLE) & req_valid;
  assign word_st = req_write & (req_size == 2'b10);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)      state_n = RESP;
          else if (word_st) state_n = WR;
          else              state_n = RD;
        end
      end
      RD:      state_n = wr_q ? WR : RESP;
      WR:      state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign MemRead    = (state == RD);
  assign MemWrite   = (state == WR);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) & err_q;
  assign resp_rdata = rdata_q;

  assign lane_b = ReadData[{off_q, 3'b000} +: 8];
  assign lane_h = off_q[1] ? ReadData[31:16] : ReadData[15:0];

  always_comb begin
    ld_data = ReadData;
    unique case (size_q)
      2'b00:   ld_data = {{24{sgn_q & lane_b[7]}}, lane_b};
      2'b01:   ld_data = {{16{sgn_q & lane_h[15]}}, lane_h};
      default: ld_data = ReadData;
    endcase
  end

  // Only the addressed lane changes; the rest of the word comes from memory.
  always_comb begin
    merged = ReadData;
    unique case (size_q)
      2'b00:   merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      sgn_q     <= 1'b0;
      off_q     <= 2'b00;
      wdata_q   <= 32'h0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      Address   <= 32'h0;
      WriteData <= 32'h0;
    end else begin
      if (accept) begin
        wr_q      <= req_write;
        size_q    <= req_size;
        sgn_q     <= req_signed;
        off_q     <= req_addr[1:0];
        wdata_q   <= req_wdata;
        err_q     <= req_err;
        rdata_q   <= 32'h0;
        Address   <= widx;
        WriteData <= req_wdata;
      end
      if (state == RD) begin
        if (wr_q) WriteData <= merged;
        else      rdata_q   <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against an arithmetic memory model.
// Includes a behavioural RAM hooked to the memory port.
module tb_lsu_mem_ctrl;

  localparam int MW = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemRead;
  logic        MemWrite;

  logic [31:0] mem [MW];
  logic [31:0] ref_mem [MW];

  int n_chk = 0;
  int n_pass = 0;
  int n_acc = 0;
  int n_rd = 0;
  int n_wr = 0;
  int viol = 0;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_WORDS(MW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .Address    (Address),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite)
  );

  assign ReadData = (MemRead && Address < MW) ? mem[Address[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (MemWrite && Address < MW) mem[Address[6:0]] <= WriteData;
  end

  always @(posedge clk) begin
    if (req_valid && req_ready) n_acc++;
    if (MemRead) n_rd++;
    if (MemWrite) begin
      n_wr++;
      wr_addr = Address;
      wr_data = WriteData;
    end
    if (MemRead && MemWrite) viol++;
    if (req_ready && (MemRead || MemWrite || resp_valid)) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] d, input bit hold);
    logic [31:0] idx, word, v, nw;
    bit err;
    int sh, lat, cyc, r0, w0, a0, exp_lat, exp_rd, exp_wr;
    idx = a >> 2;
    err = (sz == 2'b11) || (sz == 2'b01 && a[0])
       || (sz == 2'b10 && a[1:0] != 2'b00) || (idx >= MW);
    word = (idx < MW) ? ref_mem[idx[6:0]] : 32'h0;
    v = 32'h0;
    nw = word;
    if (sz == 2'b00) begin
      sh = 8 * a[1:0];
      v = (word >> sh) & 32'hFF;
      if (sg && v > 127) v += 32'hFFFF_FF00;
      nw = (word & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
    end else if (sz == 2'b01) begin
      sh = 16 * a[1];
      v = (word >> sh) & 32'hFFFF;
      if (sg && v > 32767) v += 32'hFFFF_0000;
      nw = (word & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
    end else begin
      v = word;
      nw = d;
    end
    if (err || w) v = 32'h0;
    exp_lat = err ? 1 : (w && sz != 2'b10) ? 3 : 2;
    exp_rd  = (err || (w && sz == 2'b10)) ? 0 : 1;
    exp_wr  = (!err && w) ? 1 : 0;

    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ready_wait", 32'(req_ready), 32'h1);
    r0 = n_rd;
    w0 = n_wr;
    a0 = n_acc;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_valid", 32'(resp_valid), 32'h1);
    check("resp_err", 32'(resp_err), 32'(err));
    check("resp_rdata", resp_rdata, v);
    check("ready_resp", 32'(req_ready), 32'h0);
    check("accepts", 32'(n_acc - a0), 32'h1);
    check("n_memread", 32'(n_rd - r0), 32'(exp_rd));
    check("n_memwrite", 32'(n_wr - w0), 32'(exp_wr));
    if (exp_wr == 1) begin
      check("wr_addr", wr_addr, idx);
      check("wr_data", wr_data, nw);
      ref_mem[idx[6:0]] = nw;
    end
    if (idx < MW) check("mem_word", mem[idx[6:0]], ref_mem[idx[6:0]]);
    @(posedge clk); #1;
    check("resp_pulse", 32'(resp_valid), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0] sz;
    int k, w0;
    for (int i = 0; i < MW; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_memread", 32'(MemRead), 32'h0);
    check("rst_memwrite", 32'(MemWrite), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'h0);
    check("rst_address", Address, 32'h0);
    check("rst_wdata", WriteData, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b0, 2'b10, 1'b1, 32'h10, $urandom, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 1'b0);
    d = ($urandom & 32'hFFFF_FF00) | 32'hAA;
    do_req(1'b1, 2'b00, 1'b1, 32'h12, d, 1'b0);
    check("byte_merge", ref_mem[4], 32'h11AA_3344);
    do_req(1'b0, 2'b00, 1'b1, 32'h12, $urandom, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'h12, $urandom, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h5A5A_8001, 1'b0);
    check("half_merge", ref_mem[5], 32'h8001_0000);
    do_req(1'b0, 2'b01, 1'b1, 32'h16, $urandom, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'h16, $urandom, 1'b0);

    do_req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 32'h06, 32'h1234_5678, 1'b0);
    do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0);

    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
    do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b1);
    do_req(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1'b1);
    req_valid = 1'b0;

    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'b00;
    req_addr = 32'h21;
    req_wdata = 32'h55;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    w0 = n_wr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_in_rd", 32'(MemRead), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_memread", 32'(MemRead), 32'h0);
    check("abort_memwrite", 32'(MemWrite), 32'h0);
    check("abort_resp", 32'(resp_valid), 32'h0);
    check("abort_address", Address, 32'h0);
    check("abort_wdata", WriteData, 32'h0);
    check("abort_ready", 32'(req_ready), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_no_write", 32'(n_wr - w0), 32'h0);
    check("abort_mem", mem[8], 32'hCAFE_F00D);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      sz = (k == 9) ? 2'b11 : 2'(k % 3);
      a = $urandom_range(0, 4 * MW + 63);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             a, $urandom, 1'b0);
    end

    check("strobe_rules", 32'(viol), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
